// File: rtl/alu_definitions_pkg.sv
// Shared types for the ALU command interface: op encoding, status flags and
// debug helpers.
package alu_definitions;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpNor = 3'd5,
    OpSlt = 3'd6,
    OpSll = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  localparam int unsigned ALU_PIPE_DEPTH = 2;

  function automatic string get_op_name(alu_op_t op);
    case (op)
      OpAdd:   return "ADD";
      OpSub:   return "SUB";
      OpAnd:   return "AND";
      OpOr:    return "OR";
      OpXor:   return "XOR";
      OpNor:   return "NOR";
      OpSlt:   return "SLT";
      OpSll:   return "SLL";
      default: return "???";
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: {op, a, b} -> {result, flags}.
module alu_core
  import alu_definitions::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    diff  = {1'b0, a_i} - {1'b0, b_i};
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op_i)
      OpAdd: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[Msb] == b_i[Msb]) && (sum[Msb] != a_i[Msb]);
      end
      OpSub: begin
        // Extended MSB of the difference is the unsigned borrow.
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a_i[Msb] != b_i[Msb]) && (diff[Msb] != a_i[Msb]);
      end
      OpAnd:   res = a_i & b_i;
      OpOr:    res = a_i | b_i;
      OpXor:   res = a_i ^ b_i;
      OpNor:   res = ~(a_i | b_i);
      OpSlt:   res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OpSll:   res = a_i << b_i[1:0];
      default: res = '0;
    endcase
    result_o         = res;
    flags_o.zero     = (res == '0);
    flags_o.carry    = carry;
    flags_o.overflow = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a completed-op counter.
module alu_pipe
  import alu_definitions::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  alu_op_t          in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output alu_flags_t       out_flags_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [CNT_W-1:0] op_count_o
);

  logic             s1_valid_q, s1_valid_d;
  alu_op_t          s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i    (s1_op_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .result_o(core_result),
    .flags_o (core_flags)
  );

  always_comb begin
    s2_adv      = !s2_valid_q || out_ready_i;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    s2_tag_d    = s2_tag_q;
    count_d     = count_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_op_d  = in_op_i;
        s1_a_d   = in_a_i;
        s1_b_d   = in_b_i;
        s1_tag_d = in_tag_i;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = core_result;
        s2_flags_d  = core_flags;
        s2_tag_d    = s1_tag_q;
      end
    end
    if (s2_valid_q && out_ready_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OpAdd;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_tag_q    <= '0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      s2_tag_q    <= s2_tag_d;
      count_q     <= count_d;
    end
  end

  assign in_ready_o   = s1_adv;
  assign out_valid_o  = s2_valid_q;
  assign out_result_o = s2_result_q;
  assign out_flags_o  = s2_flags_q;
  assign out_tag_o    = s2_tag_q;
  assign op_count_o   = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  import alu_definitions::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  alu_op_t          in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  alu_flags_t       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_tag_i    (in_tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_result_o(out_result),
    .out_flags_o (out_flags),
    .out_tag_o   (out_tag),
    .op_count_o  (op_count)
  );

  typedef struct {
    alu_op_t     op;
    logic [31:0] res;
    logic [2:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_count = 0;
  int          out_fires = 0;
  int          cyc = 0;
  bit          bp_random = 0;
  bit          hold_prev = 0;
  logic [31:0] prev_res;
  logic [2:0]  prev_flags;
  logic [3:0]  prev_tag;

  function automatic exp_t model(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
    exp_t            e;
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          s;
    logic [31:0]     r = '0;
    bit              c = 0;
    bit              v = 0;
    case (op)
      OpAdd: begin
        r = 32'(ua + ub);
        c = (ua + ub) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > SMAX) || (s < SMIN);
      end
      OpSub: begin
        r = 32'(ua - ub);
        c = ua < ub;
        s = sa - sb;
        v = (s > SMAX) || (s < SMIN);
      end
      OpAnd: r = a & b;
      OpOr:  r = a | b;
      OpXor: r = a ^ b;
      OpNor: r = ~(a | b);
      OpSlt: r = (sa < sb) ? 32'd1 : 32'd0;
      OpSll: r = 32'(ua * (64'd1 << (ub % 4)));
      default: r = '0;
    endcase
    e.op    = op;
    e.res   = r;
    e.flags = {(r == 32'd0), c, v};
    e.tag   = tag;
    return e;
  endfunction

  // One clock: entered at posedge+1 with inputs driven, returns at next posedge+1.
  task automatic cycle(output bit in_fired);
    exp_t e;
    if (bp_random) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (hold_prev) begin
      vectors++;
      if (out_valid !== 1'b1 || out_result !== prev_res || out_flags !== prev_flags ||
          out_tag !== prev_tag) begin
        miscompares++;
        $display("FAIL hold_stable: got v=%b r=%h f=%b t=%h, required v=1 r=%h f=%b t=%h",
                 out_valid, out_result, out_flags, out_tag, prev_res, prev_flags, prev_tag);
      end
    end
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result: got r=%h t=%h, required no output", out_result,
                 out_tag);
      end else begin
        e = exp_q.pop_front();
        if (out_result !== e.res || out_flags !== e.flags || out_tag !== e.tag) begin
          miscompares++;
          $display("FAIL result_%s: got r=%h f=%b t=%h, required r=%h f=%b t=%h",
                   get_op_name(e.op), out_result, out_flags, out_tag, e.res, e.flags, e.tag);
        end
      end
      exp_count++;
      out_fires++;
    end
    in_fired = in_valid && in_ready;
    if (in_fired) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
    hold_prev  = out_valid && !out_ready;
    prev_res   = out_result;
    prev_flags = out_flags;
    prev_tag   = out_tag;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bit f = 0;
    int n = 0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    while (!f && n < 50) begin
      cycle(f);
      n++;
    end
    if (!f) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: got in_ready stuck 0, required acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      cycle(f);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    exp_q.delete();
    exp_count = 0;
    hold_prev = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; in_op = OpAdd; in_a = '0; in_b = '0; in_tag = '0;
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_flags !== 3'b000 || out_tag !== '0 ||
        op_count !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b r=%h f=%b t=%h cnt=%0d rdy=%b, required 0/0/0/0/0/1",
               out_valid, out_result, out_flags, out_tag, op_count, in_ready);
    end
  endtask

  task automatic test_directed();
    alu_op_t     ops[6] = '{OpAdd, OpSub, OpSub, OpSlt, OpSll, OpNor};
    logic [31:0] va[6]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0};
    logic [31:0] vb[6]  = '{32'h1, 32'h1, 32'h2, 32'h1, 32'h6, 32'h0};
    logic [31:0] er[6]  = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h4, 32'hFFFF_FFFF};
    logic [2:0]  ef[6]  = '{3'b110, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
    bit f;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_op = ops[i]; in_a = va[i]; in_b = vb[i]; in_tag = 4'(i + 9); in_valid = 1'b1;
      cycle(f);
      in_valid = 1'b0;
      vectors++;
      if (!f || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early_%s: got acc=%b v=%b, required acc=1 v=0",
                 get_op_name(ops[i]), f, out_valid);
      end
      cycle(f);
      vectors++;
      if (out_valid !== 1'b1 || out_result !== er[i] || out_flags !== ef[i] ||
          out_tag !== 4'(i + 9)) begin
        miscompares++;
        $display("FAIL directed_%s: got v=%b r=%h f=%b t=%h, required v=1 r=%h f=%b t=%h",
                 get_op_name(ops[i]), out_valid, out_result, out_flags, out_tag, er[i], ef[i],
                 4'(i + 9));
      end
      cycle(f);
    end
    vectors++;
    if (op_count !== 16'd6) begin
      miscompares++;
      $display("FAIL directed_count: got %0d, required 6", op_count);
    end
  endtask

  task automatic test_backpressure();
    bit f;
    int fires0;
    do_reset();
    out_ready = 1'b0;
    in_op = OpAdd; in_a = 32'd5; in_b = 32'd7; in_valid = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      in_tag = 4'(t);
      cycle(f);
      vectors++;
      if (!f) begin
        miscompares++;
        $display("FAIL bp_accept_tag%0d: got 0, required 1", t);
      end
    end
    in_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_tag !== 4'd1) begin
        miscompares++;
        $display("FAIL bp_full: got rdy=%b tag=%h, required rdy=0 tag=1", in_ready, out_tag);
      end
      cycle(f);
    end
    out_ready = 1'b1;
    fires0 = out_fires;
    cycle(f);
    in_valid = 1'b0;
    vectors++;
    if (!f) begin
      miscompares++;
      $display("FAIL bp_release_accept: got 0, required 1");
    end
    cycle(f);
    cycle(f);
    vectors++;
    if (out_fires - fires0 != 3) begin
      miscompares++;
      $display("FAIL bp_consecutive: got %0d results in 3 cycles, required 3",
               out_fires - fires0);
    end
    drain();
    vectors++;
    if (op_count !== 16'd3) begin
      miscompares++;
      $display("FAIL bp_count: got %0d, required 3", op_count);
    end
  endtask

  task automatic test_stream();
    int c0, f0;
    out_ready = 1'b1;
    c0 = cyc;
    f0 = out_fires;
    for (int i = 0; i < 100; i++) begin
      issue(alu_op_t'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom));
    end
    drain();
    vectors++;
    if (out_fires - f0 != 100 || cyc - c0 != 102) begin
      miscompares++;
      $display("FAIL stream_throughput: got %0d results in %0d cycles, required 100 in 102",
               out_fires - f0, cyc - c0);
    end
  endtask

  task automatic test_random_bp();
    bp_random = 1;
    for (int i = 0; i < 80; i++) begin
      issue(alu_op_t'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), 4'($urandom));
    end
    bp_random = 0;
    out_ready = 1'b1;
    drain();
    vectors++;
    if (op_count !== CNT_W'(exp_count)) begin
      miscompares++;
      $display("FAIL random_bp_count: got %0d, required %0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_midstream();
    bit f;
    int f0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(OpXor, $urandom, $urandom, 4'(i));
    drain();
    out_ready = 1'b0;
    issue(OpOr, 32'h1234, 32'h1, 4'hA);
    issue(OpAnd, 32'hFFFF, 32'hF0F0, 4'hB);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fill: got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || op_count !== '0 || out_result !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b cnt=%0d r=%h rdy=%b, required 0/0/0/1",
               out_valid, op_count, out_result, in_ready);
    end
    exp_q.delete();
    exp_count = 0;
    hold_prev = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    f0 = out_fires;
    for (int k = 0; k < 5; k++) cycle(f);
    vectors++;
    if (out_fires != f0 || op_count !== '0) begin
      miscompares++;
      $display("FAIL mid_stale: got %0d results cnt=%0d, required 0/0", out_fires - f0,
               op_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_random_bp();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined ALU execution unit that consumes `alu_op_t` commands from the `alu_definitions` package and returns results with status flags. It is the responder end of the ALU command interface. Requesters present an op, two operands and a tag over a valid/ready handshake. Results, flags and tag return in order over a second valid/ready handshake, with full backpressure and one-op-per-cycle throughput.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 4.
- `TAG_W`, 4: width of the opaque request tag.
- `CNT_W`, 16: width of the completed-op counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command valid.
- `in_ready` out 1: unit can accept a command this cycle.
- `in_op` in 3 (`alu_op_t`): operation.
- `in_a`, `in_b` in WIDTH: operands.
- `in_tag` in TAG_W: returned unchanged with the result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out WIDTH: result.
- `out_flags` out 3 (`alu_flags_t`): {zero, carry, overflow}.
- `out_tag` out TAG_W: tag of the result.
- `op_count` out CNT_W: number of results consumed since reset.

## Operation
- Stage S1 (input register) holds {op, a, b, tag, valid}.
- Stage S2 (output register) holds {result, flags, tag, valid}.
- Sub-module `alu_core` computes the result from S1 combinationally.
- Arithmetic:
  - ADD: `a+b` modulo 2^WIDTH; carry = carry-out; overflow = signed overflow.
  - SUB: `a-b` modulo 2^WIDTH; carry = borrow (unsigned a < b); overflow = signed overflow.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare; result 1 if a < b, else 0, zero-extended.
  - SLL: `a << b[1:0]`; upper bits of b are ignored.
  - zero = (result == 0) for all ops. carry and overflow are 0 for every op except ADD/SUB.
- Handshake:
  - An input transfer occurs on an edge where `in_valid && in_ready`.
  - An output transfer occurs on an edge where `out_valid && out_ready`.
  - While `out_valid` is high and `out_ready` is low, `out_*` holds stable.
  - Requester must hold `in_*` stable while `in_valid && !in_ready`.
- Advance logic:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`. This is a combinational path from `out_ready`; it is accepted.
- S2 loads from S1 when `s2_adv`. `s2_valid` takes `s1_valid` on that edge.
- `op_count` increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Simultaneous output transfer and S1→S2 move in the same edge: S2 is replaced; no bubble, no loss.
- Ops are never dropped, duplicated or reordered.

## Timing
- Reset (async assert, synchronous to `clk` on deassert):
  - `s1_valid`, `s2_valid`, `out_valid` = 0.
  - `out_result`, `out_flags`, `out_tag` = 0.
  - `op_count` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- Latency: command accepted at edge k → `out_valid` high after edge k+1, when `out_ready` was high or S2 was empty at k+1.
- Throughput: one op per cycle while `out_ready` stays high.
- Capacity: 2 ops in flight. When both stages are full and `out_ready` = 0, `in_ready` = 0.
- Reset mid-operation discards all in-flight ops with no output transfer. `op_count` clears.

## Structure
- Add to `alu_definitions`:
  - `typedef struct packed {logic zero, carry, overflow;} alu_flags_t`.
  - Constant `ALU_PIPE_DEPTH = 2`.
  - Reuse `alu_op_t` and `get_op_name` for bench messages.
- One sub-module, `alu_core`: purely combinational {op, a, b} → {result, flags}, parameterized by WIDTH. `alu_pipe` holds the registers, handshake and counter.

## Test plan
- ADD a=0xFFFFFFFF, b=0x1, `out_ready`=1 → after 2 cycles: result 0x0, flags zero=1 carry=1 overflow=0, tag echoed.
- SUB a=0x80000000, b=0x1 → 0x7FFFFFFF, overflow=1, carry=0. SUB a=0x1, b=0x2 → 0xFFFFFFFF, carry=1.
- SLT a=0xFFFFFFFF (−1), b=0x1 → 0x1. SLL a=0x1, b=0x6 → 0x4. NOR a=b=0 → 0xFFFFFFFF.
- Backpressure: hold `out_ready`=0 and offer tags 1,2,3 back-to-back. Tags 1,2 are accepted, then `in_ready`=0 with tag 3 held. Raise `out_ready` → results arrive with tags 1,2,3 on consecutive cycles. `op_count`=3.
- Streaming: 100 random ops with `out_ready`=1 → one result per cycle after the first, all matching a reference model, in order.
- Reset mid-stream: assert `rst_n`=0 with 2 ops in flight → `out_valid`=0 and `op_count`=0 immediately. No stale result appears after release.
